// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch and data ports.
// Each access takes a fixed LATENCY cycles and finishes with a one-cycle ready pulse to its requester.
module unified_mem_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  dbg_sel,
    output logic [31:0] dbg_data
);

    localparam logic [3:0] LAT_C = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic        r_grant;
    logic        r_last_grant;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;
    logic        w_grant_en;
    logic        w_grant_side;
    logic        w_busy;

    // Grant decision; only IDLE may grant, and a conflict goes to the side not served last.
    always_comb begin
        w_grant_en   = 1'b0;
        w_grant_side = 1'b0;
        if (r_state == ST_IDLE) begin
            if (if_req && d_req) begin
                w_grant_en   = 1'b1;
                w_grant_side = ~r_last_grant;
            end else if (d_req) begin
                w_grant_en   = 1'b1;
                w_grant_side = 1'b1;
            end else if (if_req) begin
                w_grant_en   = 1'b1;
                w_grant_side = 1'b0;
            end else begin
                w_grant_en   = 1'b0;
                w_grant_side = 1'b0;
            end
        end else begin
            w_grant_en   = 1'b0;
            w_grant_side = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: w_next_state = w_grant_en ? ST_BUSY : ST_IDLE;
            ST_BUSY: w_next_state = (r_cnt == 4'd1) ? ST_DONE : ST_BUSY;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Grant latch, access countdown and read-data capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= 4'd0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_if_rdata   <= 32'd0;
            r_d_rdata    <= 32'd0;
        end else if (w_grant_en) begin
            r_grant      <= w_grant_side;
            r_last_grant <= w_grant_side;
            r_we         <= w_grant_side & d_we;
            r_addr       <= w_grant_side ? d_addr : if_addr;
            r_wdata      <= w_grant_side ? d_wdata : 32'd0;
            r_cnt        <= LAT_C;
        end else if (r_state == ST_BUSY) begin
            r_cnt <= r_cnt - 4'd1;
            // Last access cycle: mem_rdata is valid now, stores leave d_rdata untouched.
            if ((r_cnt == 4'd1) && !r_we) begin
                if (r_grant) begin
                    r_d_rdata <= mem_rdata;
                end else begin
                    r_if_rdata <= mem_rdata;
                end
            end
        end
    end

    // Output decode straight from registers so reset clears the strobes asynchronously.
    always_comb begin
        w_busy    = (r_state == ST_BUSY);
        mem_en    = w_busy && (r_cnt == LAT_C);
        mem_we    = mem_en && r_we;
        mem_addr  = w_busy ? r_addr : 32'd0;
        mem_wdata = w_busy ? r_wdata : 32'd0;
        if_ready  = (r_state == ST_DONE) && !r_grant;
        d_ready   = (r_state == ST_DONE) && r_grant;
        if_rdata  = r_if_rdata;
        d_rdata   = r_d_rdata;
        case (dbg_sel)
            2'b00:   dbg_data = {16'd0, r_cnt, 3'd0, r_last_grant, 3'd0, r_grant, 2'd0, 2'(r_state)};
            2'b01:   dbg_data = r_addr;
            2'b10:   dbg_data = r_if_rdata;
            2'b11:   dbg_data = r_d_rdata;
            default: dbg_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: a transaction-level model predicts accesses and
// ready pulses, and a negedge monitor pops and compares them against what the DUT presents.
module tb_unified_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata;
    logic        if_ready, d_ready;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  dbg_sel;
    logic [31:0] dbg_data;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Physical memory seen by the DUT and the model's own view of memory contents.
    logic [31:0] phys [int unsigned];
    logic [31:0] mm   [int unsigned];
    logic [31:0] hold_r = 32'd0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] rd_phys(input logic [31:0] a);
        if (phys.exists(a)) return phys[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] rd_mm(input logic [31:0] a);
        if (mm.exists(a)) return mm[a];
        return init_word(a);
    endfunction

    assign mem_rdata = (LAT == 1) ? rd_phys(mem_addr) : hold_r;

    // Synchronous memory: reads registered on the strobe edge, writes applied on it.
    initial forever begin
        @(posedge clk);
        if (reset && mem_en) begin
            if (mem_we) phys[mem_addr] = mem_wdata;
            else hold_r <= rd_phys(mem_addr);
        end
    end

    typedef struct { bit side; logic [31:0] addr; bit we; logic [31:0] wdata; int cyc; } acc_t;
    typedef struct { bit side; logic [31:0] data; int cyc; } rdy_t;
    acc_t acc_q[$];
    rdy_t rdy_q[$];

    int          cyc = 0;
    int          m_next = 0;
    bit          m_last = 1'b0;
    logic [31:0] m_if_last = 32'd0;
    logic [31:0] m_d_last = 32'd0;

    // Reference model: a sampled request in cycle c gives a strobe in c+1, ready in c+LAT+1,
    // and the arbiter is next free to sample in c+LAT+2.
    initial forever begin
        acc_t a;
        rdy_t r;
        bit   side;
        @(posedge clk);
        if (!reset) begin
            m_next = 0; m_last = 1'b0; m_if_last = 32'd0; m_d_last = 32'd0;
            acc_q.delete(); rdy_q.delete();
        end else if (cyc >= m_next && (if_req || d_req)) begin
            side    = (if_req && d_req) ? !m_last : d_req;
            a.side  = side;
            a.addr  = side ? d_addr : if_addr;
            a.we    = side && d_we;
            a.wdata = d_wdata;
            a.cyc   = cyc + 1;
            if (a.we) mm[a.addr] = a.wdata;
            else if (side) m_d_last = rd_mm(a.addr);
            else m_if_last = rd_mm(a.addr);
            r.side = side;
            r.data = side ? m_d_last : m_if_last;
            r.cyc  = cyc + LAT + 1;
            acc_q.push_back(a);
            rdy_q.push_back(r);
            m_last = side;
            m_next = cyc + LAT + 2;
        end
        cyc = cyc + 1;
    end

    // Monitor: compares every strobe and ready pulse against the scoreboard queues.
    initial forever begin
        acc_t a;
        rdy_t r;
        @(negedge clk);
        #1;
        if (reset) begin
            while (acc_q.size() > 0 && acc_q[0].cyc < cyc) begin
                a = acc_q.pop_front();
                check("mem_en_missing", 32'(mem_en), 32'd1);
            end
            while (rdy_q.size() > 0 && rdy_q[0].cyc < cyc) begin
                r = rdy_q.pop_front();
                check("ready_missing", 32'(cyc), 32'(r.cyc));
            end
            if (mem_en) begin
                if (acc_q.size() == 0) begin
                    check("mem_en_unexpected", 32'(mem_en), 32'd0);
                end else begin
                    a = acc_q.pop_front();
                    check("mem_en_cycle", 32'(cyc), 32'(a.cyc));
                    check("mem_addr", mem_addr, a.addr);
                    check("mem_we", 32'(mem_we), 32'(a.we));
                    if (a.we) check("mem_wdata", mem_wdata, a.wdata);
                end
            end else begin
                check("mem_we_idle", 32'(mem_we), 32'd0);
            end
            if (if_ready || d_ready) begin
                check("ready_exclusive", 32'(if_ready & d_ready), 32'd0);
                if (rdy_q.size() == 0) begin
                    check("ready_unexpected", 32'(if_ready | d_ready), 32'd0);
                end else begin
                    r = rdy_q.pop_front();
                    check("ready_side", 32'(d_ready), 32'(r.side));
                    check("ready_cycle", 32'(cyc), 32'(r.cyc));
                    check("ready_rdata", r.side ? d_rdata : if_rdata, r.data);
                end
            end
        end
    end

    task automatic do_txn(input bit side, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit drop_early);
        bit done;
        done = 1'b0;
        @(negedge clk);
        if (side) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (drop_early && mem_en) begin
                if (side) d_req = 1'b0; else if_req = 1'b0;
            end
            if (side ? d_ready : if_ready) done = 1'b1;
        end
        if (side) d_req = 1'b0; else if_req = 1'b0;
        check("txn_completes", 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h100 + 32'(4 * $urandom_range(0, 7));
    endfunction

    initial begin
        int   rc;
        bit   seen;
        int   rcyc[$];
        bit   rside[$];

        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; dbg_sel = 2'd0;
        repeat (3) @(negedge clk);

        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_readys", {30'd0, if_ready, d_ready}, 32'd0);
        check("rst_mem_strobes", {30'd0, mem_en, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        for (int s = 0; s < 4; s++) begin
            dbg_sel = 2'(s);
            #1;
            check("rst_dbg", dbg_data, 32'd0);
        end
        dbg_sel = 2'd0;
        reset = 1'b1;

        // Reset in the middle of a fetch abandons it.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h40;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (mem_en) seen = 1'b1;
        end
        check("busy_reached", 32'(seen), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_mem_en", 32'(mem_en), 32'd0);
        check("abort_if_ready", 32'(if_ready), 32'd0);
        check("abort_if_rdata", if_rdata, 32'd0);
        check("abort_state", {30'd0, dbg_data[1:0]}, 32'd0);
        if_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rc = 0;
        repeat (8) begin
            @(negedge clk);
            rc += int'(if_ready) + int'(d_ready);
        end
        check("no_ready_after_abort", 32'(rc), 32'd0);

        // Single fetch with a known instruction word.
        phys[32'h4] = 32'h20080005;
        mm[32'h4]   = 32'h20080005;
        do_txn(1'b0, 1'b0, 32'h4, 32'd0, 1'b0);
        check("fetch_word", if_rdata, 32'h20080005);
        dbg_sel = 2'd2;
        #1 check("dbg_if_rdata", dbg_data, 32'h20080005);
        dbg_sel = 2'd0;

        // Load, then a store that must not disturb d_rdata, then read it back.
        do_txn(1'b1, 1'b0, 32'h20, 32'd0, 1'b0);
        check("load_word", d_rdata, init_word(32'h20));
        do_txn(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        check("store_keeps_d_rdata", d_rdata, init_word(32'h20));
        do_txn(1'b1, 1'b0, 32'h10, 32'd0, 1'b0);
        check("load_after_store", d_rdata, 32'hDEADBEEF);
        dbg_sel = 2'd3;
        #1 check("dbg_d_rdata", dbg_data, 32'hDEADBEEF);
        dbg_sel = 2'd1;
        #1 check("dbg_addr", dbg_data, 32'h10);
        dbg_sel = 2'd0;

        // Load whose request is dropped right after the grant.
        do_txn(1'b1, 1'b0, 32'h30, 32'd0, 1'b1);
        check("dropped_load_word", d_rdata, init_word(32'h30));

        // Both sides held from reset: D, IF, D, IF with readys at 3, 7, 11, 15.
        @(negedge clk);
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h50;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h60;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (if_ready || d_ready) begin
                rcyc.push_back(k);
                rside.push_back(d_ready);
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        check("both_held_count", 32'(rcyc.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rcyc.size()) begin
                check("both_held_cycle", 32'(rcyc[i]), 32'(3 + 4 * i));
                check("both_held_side", 32'(rside[i]), 32'((i % 2) == 0));
            end
        end

        // Randomized traffic on both ports.
        repeat (4) @(negedge clk);
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (if_req) begin
                if (if_ready) begin
                    if_req = 1'($urandom % 2);
                    if_addr = rand_addr();
                end
            end else if ($urandom % 3 == 0) begin
                if_req = 1'b1;
                if_addr = rand_addr();
            end
            if (d_req) begin
                if (d_ready) begin
                    d_req = 1'($urandom % 2);
                    d_addr = rand_addr(); d_we = 1'($urandom % 2); d_wdata = $urandom;
                end
            end else if ($urandom % 3 == 0) begin
                d_req = 1'b1;
                d_addr = rand_addr(); d_we = 1'($urandom % 2); d_wdata = $urandom;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        repeat (20) @(negedge clk);
        check("acc_q_drained", 32'(acc_q.size()), 32'd0);
        check("rdy_q_drained", 32'(rdy_q.size()), 32'd0);
        check("final_if_rdata", if_rdata, m_if_last);
        check("final_d_rdata", d_rdata, m_d_last);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

endmodule
